// File: rtl/ven_payout.sv
// ven_payout: queues vend/change requests from the vending FSM and turns each
// one into a timed vend-motor pulse and per-coin ejector pulses.
module ven_payout #(
  parameter int VEND_CYCLES  = 8,
  parameter int EJECT_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int TIMEOUT      = 32,
  parameter int DEPTH        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend_req,
  input  logic [1:0] change_req,
  input  logic       drop_sense,
  output logic       motor_on,
  output logic       eject,
  output logic       done,
  output logic       busy,
  output logic       overflow,
  output logic       fault
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int T1   = (VEND_CYCLES > EJECT_CYCLES) ? VEND_CYCLES : EJECT_CYCLES;
  localparam int T2   = (T1 > GAP_CYCLES) ? T1 : GAP_CYCLES;
  localparam int TMAX = (T2 > TIMEOUT) ? T2 : TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [TW-1:0] VEND_LAST  = TW'(VEND_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] EJECT_LAST = TW'(EJECT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, VEND, WAIT_DROP, EJECT, GAP} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic [1:0]    coins;
  logic          timeout_hit;
  logic          motor_nxt, eject_nxt, done_nxt;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [2:0]    head;
  logic [1:0]    req_coins;
  logic          req_valid, full, push, pop;

  // Illegal change code 11 collapses to "no change owed".
  always_comb begin
    case (change_req)
      2'b01:   req_coins = 2'd1;
      2'b10:   req_coins = 2'd2;
      default: req_coins = 2'd0;
    endcase
  end

  assign req_valid = vend_req | (req_coins != 2'd0);
  assign full      = (count == FULL_CNT);
  assign push      = req_valid & ~full;
  assign pop       = (state == IDLE) && (count != '0);
  assign head      = mem[rd_ptr];
  assign busy      = (count != '0) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {vend_req, req_coins};
  end

  // Full is judged on the pre-edge count, so a pop cannot rescue a push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (req_valid && full) overflow <= 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      coins    <= '0;
      fault    <= 1'b0;
      motor_on <= 1'b0;
      eject    <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      motor_on <= motor_nxt;
      eject    <= eject_nxt;
      done     <= done_nxt;
      if (state_nxt != state || state == IDLE) timer <= '0;
      else                                     timer <= timer + TW'(1);
      if (timeout_hit) fault <= 1'b1;
      if (pop)                                   coins <= head[1:0];
      else if (state == EJECT && state_nxt == GAP) coins <= coins - 2'd1;
    end
  end

  // Coins are decremented on leaving EJECT, so GAP sees the remaining count.
  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:      if (pop) state_nxt = head[2] ? VEND : EJECT;
      VEND:      if (timer == VEND_LAST) state_nxt = WAIT_DROP;
      WAIT_DROP: if (drop_sense || timer == WAIT_LAST) begin
                   timeout_hit = ~drop_sense;
                   state_nxt   = (coins != 2'd0) ? EJECT : IDLE;
                 end
      EJECT:     if (timer == EJECT_LAST) state_nxt = GAP;
      GAP:       if (timer == GAP_LAST) state_nxt = (coins != 2'd0) ? EJECT : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    motor_nxt = (state_nxt == VEND);
    eject_nxt = (state_nxt == EJECT);
    done_nxt  = (state_nxt == IDLE) && (state != IDLE);
  end

endmodule

// File: tb/tb_ven_payout.sv
// tb_ven_payout: directed scenario table, hand-written corner sequences and
// random traffic, all checked against a per-cycle transaction-schedule model.
module tb_ven_payout;

  localparam int VEND_CYCLES  = 8;
  localparam int EJECT_CYCLES = 4;
  localparam int GAP_CYCLES   = 2;
  localparam int TIMEOUT      = 32;
  localparam int DEPTH        = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vend_req = 1'b0;
  logic [1:0] change_req = 2'b00;
  logic       drop_sense = 1'b0;
  logic       motor_on, eject, done, busy, overflow, fault;

  ven_payout #(
    .VEND_CYCLES(VEND_CYCLES), .EJECT_CYCLES(EJECT_CYCLES), .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT(TIMEOUT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .vend_req(vend_req), .change_req(change_req),
    .drop_sense(drop_sense), .motor_on(motor_on), .eject(eject), .done(done),
    .busy(busy), .overflow(overflow), .fault(fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: each popped transaction expands into a schedule of per-cycle tokens.
  typedef enum int {T_IDLE, T_MOTOR, T_WAIT, T_EJECT, T_GAP} tok_t;
  typedef struct { bit vend; int coins; } txn_t;

  txn_t fifo_q[$];
  tok_t sched[$];
  tok_t cur_tok = T_IDLE;
  int   wcnt = 0;
  int   pend_coins = 0;
  bit   active = 0, m_fault = 0, m_overflow = 0, m_done = 0;

  function automatic void add_coins(int n);
    for (int i = 0; i < n; i++) begin
      repeat (EJECT_CYCLES) sched.push_back(T_EJECT);
      repeat (GAP_CYCLES) sched.push_back(T_GAP);
    end
  endfunction

  function automatic tok_t next_from_sched();
    tok_t t;
    if (sched.size() > 0) begin
      t = sched.pop_front();
      if (t == T_WAIT) wcnt = 0;
      return t;
    end
    if (active) begin
      active = 0;
      m_done = 1;
    end
    return T_IDLE;
  endfunction

  function automatic void model_step();
    tok_t ended;
    bit   full_pre, req_valid;
    int   req_coins;
    txn_t t;
    if (rst) begin
      fifo_q.delete();
      sched.delete();
      cur_tok = T_IDLE; wcnt = 0; pend_coins = 0;
      active = 0; m_fault = 0; m_overflow = 0; m_done = 0;
      return;
    end
    ended     = cur_tok;
    m_done    = 0;
    full_pre  = (fifo_q.size() == DEPTH);
    req_coins = (change_req == 2'b01) ? 1 : (change_req == 2'b10) ? 2 : 0;
    req_valid = vend_req || (req_coins > 0);
    if (ended == T_IDLE && fifo_q.size() > 0) begin
      t = fifo_q.pop_front();
      active = 1;
      if (t.vend) begin
        repeat (VEND_CYCLES) sched.push_back(T_MOTOR);
        sched.push_back(T_WAIT);
        pend_coins = t.coins;
      end else begin
        add_coins(t.coins);
      end
    end
    if (req_valid) begin
      if (full_pre) m_overflow = 1;
      else begin
        t.vend  = vend_req;
        t.coins = req_coins;
        fifo_q.push_back(t);
      end
    end
    if (ended == T_WAIT && !(drop_sense || wcnt == TIMEOUT - 1)) begin
      wcnt++;
      cur_tok = T_WAIT;
    end else begin
      if (ended == T_WAIT) begin
        if (!drop_sense) m_fault = 1;
        add_coins(pend_coins);
        pend_coins = 0;
      end
      cur_tok = next_from_sched();
    end
  endfunction

  int cyc;
  int st_mf, st_mc, st_ef, st_ep, st_ec, st_df, st_dc, st_ff, st_of;
  bit st_busy, prev_eject;

  task automatic reset_stats();
    cyc = 0;
    st_mf = -1; st_mc = 0; st_ef = -1; st_ep = 0; st_ec = 0;
    st_df = -1; st_dc = 0; st_ff = -1; st_of = -1;
    st_busy = 0; prev_eject = 0;
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [5:0] exp_v, act_v;
    exp_v = {cur_tok == T_MOTOR, cur_tok == T_EJECT, m_done,
             (fifo_q.size() > 0) || (cur_tok != T_IDLE), m_overflow, m_fault};
    act_v = {motor_on, eject, done, busy, overflow, fault};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("[TB] FAIL outputs at t=%0t: motor/eject/done/busy/ovf/fault got %b expected %b",
               $time, act_v, exp_v);
    end
  endtask

  // Drives one cycle of inputs, advances DUT and model, compares, records stats.
  task automatic applyStimulus(input logic v, input logic [1:0] c, input logic d, input logic r);
    vend_req = v; change_req = c; drop_sense = d; rst = r;
    @(posedge clk);
    model_step();
    #1;
    checkOutput();
    if (motor_on) begin
      if (st_mf < 0) st_mf = cyc + 1;
      st_mc++;
    end
    if (eject) begin
      if (st_ef < 0) st_ef = cyc + 1;
      st_ec++;
      if (!prev_eject) st_ep++;
    end
    prev_eject = eject;
    if (done) begin
      if (st_df < 0) st_df = cyc + 1;
      st_dc++;
    end
    if (fault && st_ff < 0) st_ff = cyc + 1;
    if (overflow && st_of < 0) st_of = cyc + 1;
    if (busy) st_busy = 1;
    cyc++;
  endtask

  typedef struct {
    logic       v;
    logic [1:0] c;
    int         drop_cyc;
    int         exp_mf, exp_mc, exp_ef, exp_ep, exp_ec, exp_df, exp_ff;
    bit         exp_busy;
  } vec_t;

  vec_t vecs[7];

  task automatic do_reset();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
    checkValue("reset_outputs", int'({motor_on, eject, done, busy, overflow, fault}), 0);
    reset_stats();
  endtask

  initial begin
    int ej9, ovf5;
    vecs[0] = '{1'b1, 2'b00, 12, 2, 8, -1, 0, 0, 13, -1, 1'b1};
    vecs[1] = '{1'b0, 2'b10, -1, -1, 0, 2, 2, 8, 14, -1, 1'b1};
    vecs[2] = '{1'b1, 2'b01, -1, 2, 8, 42, 1, 4, 48, 42, 1'b1};
    vecs[3] = '{1'b0, 2'b11, -1, -1, 0, -1, 0, 0, -1, -1, 1'b0};
    vecs[4] = '{1'b1, 2'b11, 10, 2, 8, -1, 0, 0, 11, -1, 1'b1};
    vecs[5] = '{1'b1, 2'b10, 11, 2, 8, 12, 2, 8, 24, -1, 1'b1};
    vecs[6] = '{1'b0, 2'b01, -1, -1, 0, 2, 1, 4, 8, -1, 1'b1};

    for (int s = 0; s < 7; s++) begin
      do_reset();
      for (int k = 0; k < 60; k++)
        applyStimulus((k == 0) ? vecs[s].v : 1'b0, (k == 0) ? vecs[s].c : 2'b00,
                      k == vecs[s].drop_cyc, 1'b0);
      checkValue($sformatf("s%0d motor_first", s), st_mf, vecs[s].exp_mf);
      checkValue($sformatf("s%0d motor_cycles", s), st_mc, vecs[s].exp_mc);
      checkValue($sformatf("s%0d eject_first", s), st_ef, vecs[s].exp_ef);
      checkValue($sformatf("s%0d eject_pulses", s), st_ep, vecs[s].exp_ep);
      checkValue($sformatf("s%0d eject_cycles", s), st_ec, vecs[s].exp_ec);
      checkValue($sformatf("s%0d done_cycle", s), st_df, vecs[s].exp_df);
      checkValue($sformatf("s%0d done_count", s), st_dc, (vecs[s].exp_df >= 0) ? 1 : 0);
      checkValue($sformatf("s%0d fault_first", s), st_ff, vecs[s].exp_ff);
      checkValue($sformatf("s%0d busy_seen", s), int'(st_busy), int'(vecs[s].exp_busy));
    end

    // Overflow: six back-to-back 5-unit requests, the sixth meets a full FIFO.
    do_reset();
    ovf5 = -1;
    for (int k = 0; k < 60; k++) begin
      applyStimulus(1'b0, (k <= 5) ? 2'b01 : 2'b00, 1'b0, 1'b0);
      if (k == 4) ovf5 = int'(overflow);
    end
    checkValue("ovf low at cycle 5", ovf5, 0);
    checkValue("ovf first cycle", st_of, 6);
    checkValue("ovf eject_pulses", st_ep, 5);
    checkValue("ovf done_count", st_dc, 5);
    checkValue("ovf still set", int'(overflow), 1);

    // Reset during the second coin pulse of a 10-unit change with one more queued.
    do_reset();
    ej9 = -1;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b0, (k == 0) ? 2'b10 : (k == 1) ? 2'b01 : 2'b00, 1'b0, 1'b0);
      if (k == 8) ej9 = int'(eject);
    end
    checkValue("midrst eject before reset", ej9, 1);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
    checkValue("midrst outputs cleared",
               int'({motor_on, eject, done, busy, overflow, fault}), 0);
    reset_stats();
    for (int k = 0; k < 30; k++) applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    checkValue("midrst later eject", st_ec, 0);
    checkValue("midrst later done", st_dc, 0);
    checkValue("midrst later busy", int'(st_busy), 0);

    // Random traffic, drop sensor noise and occasional resets.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      logic v, d, r;
      logic [1:0] c;
      v = ($urandom_range(0, 19) == 0);
      c = ($urandom_range(0, 14) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      d = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 599) == 0);
      applyStimulus(v, c, d, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ven_payout.md
# ven_payout

Payout sequencer for the vending datapath. It sits downstream of the vending FSM and consumes its one-cycle `out` (vend) and `change` outputs. Each request is queued, then turned into timed actuator pulses: a vend-motor pulse with drop-sensor confirmation, and one 5-unit coin-ejector pulse per coin of change owed. Back-to-back sales are absorbed by a small request FIFO, so the FSM never has to stall.

## Interface
- `VEND_CYCLES`, 8: cycles `motor_on` is held high per vend.
- `EJECT_CYCLES`, 4: cycles `eject` is held high per coin.
- `GAP_CYCLES`, 2: low cycles after every coin pulse.
- `TIMEOUT`, 32: maximum cycles spent waiting for `drop_sense`.
- `DEPTH`, 4: request FIFO entries (power of two, ≥2).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `vend_req`  in  1  vend request pulse, driven from FSM `out`.
- `change_req`  in  2  change owed: 00 none, 01 = 5 units, 10 = 10 units, 11 illegal.
- `drop_sense`  in  1  product-drop sensor, level, synchronous to `clk`.
- `motor_on`  out  1  vend motor drive.
- `eject`  out  1  5-unit coin ejector drive.
- `done`  out  1  one-cycle pulse on transaction completion.
- `busy`  out  1  FIFO non-empty or FSM not in IDLE.
- `overflow`  out  1  sticky: a request was dropped because the FIFO was full.
- `fault`  out  1  sticky: drop-sensor timeout occurred.

## Operation
- **Transaction capture.** A transaction exists in any cycle where `vend_req`=1 or `change_req`∈{01,10}.
  - It is encoded as {vend bit, coins}, where coins = 1 for 01 and 2 for 10.
  - `change_req`=11 is treated as 00. If `vend_req`=0 as well, nothing is queued.
- **Push.** A transaction is pushed at the clock edge if count<DEPTH. Otherwise it is dropped and `overflow` sets.
  - Full is evaluated on the pre-edge count. A push while full is dropped even if a pop occurs on the same edge.
  - A simultaneous push and pop on a non-full FIFO leaves count unchanged.
- **FSM states:** IDLE, VEND, WAIT_DROP, EJECT, GAP.
  - **IDLE:** if the FIFO is non-empty, pop on this edge. Load the vend bit and coin counter, then go to VEND if vend=1, else EJECT (coins≥1 is guaranteed).
  - **VEND:** `motor_on`=1 for exactly VEND_CYCLES cycles, then WAIT_DROP.
  - **WAIT_DROP:** sample `drop_sense` each cycle.
    - High → go to EJECT if coins>0, else IDLE.
    - After TIMEOUT cycles with no high sample → set `fault`, then proceed the same way. Change is still paid.
  - **EJECT:** `eject`=1 for EJECT_CYCLES cycles, decrement coins, then GAP.
  - **GAP:** `eject`=0 for GAP_CYCLES cycles, then EJECT if coins>0, else IDLE.
- **`done`:** pulses in the first IDLE cycle after a transaction finishes. With a non-empty FIFO, that same IDLE cycle also pops the next entry.
- **Registered outputs.** `motor_on`=(state==VEND) and `eject`=(state==EJECT), both glitch-free.
- **Reset**, at any point including mid-pulse: on the next edge the state goes to IDLE, the FIFO empties, all counters clear, and `motor_on`/`eject`/`done`/`busy`/`overflow`/`fault` all become 0.

## Timing
- Reset value of every output is 0.
- **Vend latency.** A request in cycle t is in the FIFO at t+1, popped on the t+1 edge, and `motor_on` first goes high in cycle t+2.
- **Change-only latency.** A change-only request in cycle t gives `eject` first high in cycle t+2.
- `busy` goes high in cycle t+1 and drops in the `done` cycle if the FIFO is empty.
- Minimum spacing between successive transactions is one IDLE cycle.
- **Per-transaction duration**, from first drive cycle to the `done` cycle: VEND_CYCLES + wait + coins×(EJECT_CYCLES+GAP_CYCLES). The wait is the cycles until the high sample, capped at TIMEOUT.

## Test plan
- **Vend with prompt drop.** `vend_req`=1, `change_req`=00 in cycle 0; `drop_sense`=1 in cycle 12 → `motor_on` high cycles 2–9, `done` in cycle 13, `eject` never high, `fault`=0.
- **Change-only.** `change_req`=10 in cycle 0 → `eject` high 2–5, low 6–7, high 8–11, low 12–13, `done` in cycle 14, `motor_on` never high.
- **Drop timeout.** `vend_req`=1, `change_req`=01 in cycle 0, `drop_sense` held 0 → `motor_on` high 2–9, `fault`=1 from cycle 42, `eject` high 42–45, `done` in cycle 48.
- **Overflow.** `change_req`=01 on six consecutive cycles 0–5 → five transactions accepted, `overflow`=1 from cycle 6, exactly five `eject` pulses, five `done` pulses.
- **Illegal code.** `change_req`=11 with `vend_req`=0 → nothing queued, `busy` stays 0.
- **Reset mid-operation.** `rst`=1 during the second `eject` pulse of a 10-unit change with one more entry queued → all outputs 0 on the next cycle, FIFO empty, no further pulses after `rst` drops.
